// File: rtl/mem_bridge.sv
// mem_bridge: serialises 32-bit word reads/writes into four little-endian byte beats.
// Optional alignment check enabled by defining MEM_BRIDGE_MISALIGN_CHK_EN.
module mem_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t      state;
    logic [1:0]  cnt;
    logic [1:0]  nk;
    logic [31:0] base;
    logic [31:0] wbuf;
    logic        op;
    logic        mis;
    assign nk = cnt + 2'd1;
`ifdef MEM_BRIDGE_MISALIGN_CHK_EN
    assign mis = addr[1:0] != 2'b00;
`else
    assign mis = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            base      <= 32'd0;
            wbuf      <= 32'd0;
            op        <= 1'b0;
            rdata     <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 8'd0;
        end else begin
            case (state)
                IDLE: if (req_rd || req_wr) begin
                    base     <= {addr[31:2], 2'b00};
                    mem_addr <= {addr[31:2], 2'b00};
                    wbuf     <= wdata;
                    op       <= req_wr;
                    cnt      <= 2'd0;
                    busy     <= 1'b1;
                    if (mis) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        misalign <= 1'b1;
                    end else begin
                        state     <= XFER;
                        mem_en    <= 1'b1;
                        mem_we    <= req_wr;
                        mem_wdata <= wdata[7:0];
                    end
                end
                XFER: begin
                    cnt <= nk;
                    // mem_rdata tracks the current beat address; capture it as the beat ends
                    if (!op) rdata[{cnt, 3'b000} +: 8] <= mem_rdata;
                    if (cnt == 2'd3) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= 8'd0;
                        mem_addr  <= base;
                    end else begin
                        mem_addr  <= base + {30'd0, nk};
                        mem_wdata <= wbuf[{nk, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    misalign <= 1'b0;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
